// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the Hack PC sequencer: state encodings,
// jump-field bit positions and the default start address.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_FETCH = 2'd1,
    SEQ_EXEC  = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_state_t;

  localparam int CI_BIT   = 15;
  localparam int J_LT_BIT = 2;
  localparam int J_EQ_BIT = 1;
  localparam int J_GT_BIT = 0;

  localparam logic [15:0] SEQ_START_ADDR = 16'h0000;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Hack C-instruction jump decision from the ALU flags; purely combinational.
// uncond flags the 0;JMP form used to detect the end-of-program loop.
module jump_cond
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  input  logic             zr,
  input  logic             ng,
  output logic             take,
  output logic             uncond
);

  logic w_is_c;
  logic w_unused_ir;

  assign w_is_c      = ir[CI_BIT];
  assign w_unused_ir = ^ir[CI_BIT-1:J_LT_BIT+1];

  assign take = w_is_c & ((ir[J_LT_BIT] & ng) |
                          (ir[J_EQ_BIT] & zr) |
                          (ir[J_GT_BIT] & ~ng & ~zr));

  assign uncond = w_is_c & ir[J_LT_BIT] & ir[J_EQ_BIT] & ir[J_GT_BIT];

endmodule

// File: rtl/pc_sequencer.sv
// Hack CPU fetch/execute controller: owns PC and IR, fetches over req/ack,
// resolves jumps in EXEC and halts on a jump-to-self (end-of-program loop).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] START_ADDR = WIDTH'(SEQ_START_ADDR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic             exec_en,
  output logic             halted
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic             w_take;
  logic             w_uncond;

  jump_cond #(.WIDTH(WIDTH)) u_jump_cond (
    .ir     (r_ir),
    .zr     (zr),
    .ng     (ng),
    .take   (w_take),
    .uncond (w_uncond)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      SEQ_IDLE:  if (run) w_next_state = SEQ_FETCH;
      SEQ_FETCH: if (fetch_ack) w_next_state = SEQ_EXEC;
      SEQ_EXEC: begin
        // A taken unconditional jump onto itself is the canonical program end.
        if (w_take && w_uncond && (jump_target == r_pc)) begin
          w_next_state = SEQ_HALT;
        end else if (!run) begin
          w_next_state = SEQ_IDLE;
        end else begin
          w_next_state = SEQ_FETCH;
        end
      end
      SEQ_HALT:  w_next_state = SEQ_HALT;
      default:   w_next_state = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= START_ADDR;
    end else if (r_state == SEQ_EXEC) begin
      r_pc <= w_take ? jump_target : r_pc + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir <= '0;
    end else if ((r_state == SEQ_FETCH) && fetch_ack) begin
      r_ir <= instr;
    end
  end

  assign fetch_req = (r_state == SEQ_FETCH);
  assign exec_en   = (r_state == SEQ_EXEC);
  assign halted    = (r_state == SEQ_HALT);
  assign pc        = r_pc;
  assign ir        = r_ir;

endmodule
